gcd_ctrl: RTL and testbench

GCD_CTRL -- requirements
Module: gcd_ctrl

---
 rtl/gcd_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_gcd_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/gcd_ctrl.sv
// gcd_ctrl: Moore control FSM for a subtract-based GCD datapath.
// Sequence: IDLE -> LOAD_A -> LOAD_B -> COMP -> (SUB_A | SUB_B -> COMP)* -> DONE -> IDLE.
// The strobes are decoded from the state register only. The datapath loads
// on the falling edge, so the strobes are stable when it samples them.
// res_sel and err are registered so they stay valid after done.
// Optional feature: define GCD_WDOG_EN to add a 16-bit subtract-step
// watchdog. When the step count reaches MAX_STEPS, the run is aborted with err=1.
module gcd_ctrl #(
  parameter logic [15:0] MAX_STEPS = 16'd65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic lt,
  input  logic gt,
  input  logic eq,
  input  logic az,
  input  logic bz,
  output logic ld_a,
  output logic ld_b,
  output logic sel_in,
  output logic sel1,
  output logic sel2,
  output logic busy,
  output logic done,
  output logic res_sel,
  output logic err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    COMP   = 3'd3,
    SUB_A  = 3'd4,
    SUB_B  = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   res_sel_r;
  logic   res_sel_set_s;
  logic   err_set_s;
  logic   wdog_trip_s;

`ifdef GCD_WDOG_EN
  logic [15:0] step_cnt_r;
  logic        err_r;

  assign wdog_trip_s = (step_cnt_r >= MAX_STEPS);

  // Step counter: cleared at the start of each run, counts subtract cycles, saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_cnt_r <= 16'd0;
    end else if (state_r == LOAD_A) begin
      step_cnt_r <= 16'd0;
    end else if (((state_r == SUB_A) || (state_r == SUB_B)) && (step_cnt_r != 16'hFFFF)) begin
      step_cnt_r <= step_cnt_r + 16'd1;
    end else begin
      step_cnt_r <= step_cnt_r;
    end
  end

  // Abort flag: set when the watchdog ends a run, held until the next operand load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (state_r == LOAD_A) begin
      err_r <= 1'b0;
    end else if (err_set_s) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  assign err = err_r;
`else
  logic unused_cfg_s;

  // The limit only matters when the watchdog is built in.
  assign unused_cfg_s = ^MAX_STEPS;
  assign wdog_trip_s  = 1'b0;
  assign err          = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Result-location register: cleared at operand load, set when A reached zero first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sel_r <= 1'b0;
    end else if (state_r == LOAD_A) begin
      res_sel_r <= 1'b0;
    end else if (res_sel_set_s) begin
      res_sel_r <= 1'b1;
    end else begin
      res_sel_r <= res_sel_r;
    end
  end

  assign res_sel = res_sel_r;

  // Next-state logic. COMP resolves the comparator flags in priority order.
  always_comb begin
    state_nxt_s   = state_r;
    res_sel_set_s = 1'b0;
    err_set_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = LOAD_A;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD_A: state_nxt_s = LOAD_B;
      LOAD_B: state_nxt_s = COMP;
      COMP: begin
        if (eq) begin
          state_nxt_s = DONE;
        end else if (az) begin
          state_nxt_s   = DONE;
          res_sel_set_s = 1'b1;
        end else if (bz) begin
          state_nxt_s = DONE;
        end else if (wdog_trip_s) begin
          state_nxt_s = DONE;
          err_set_s   = 1'b1;
        end else if (gt) begin
          state_nxt_s = SUB_A;
        end else if (lt) begin
          state_nxt_s = SUB_B;
        end else begin
          // Inconsistent comparator flags: end the run rather than stall.
          state_nxt_s = DONE;
        end
      end
      SUB_A:   state_nxt_s = COMP;
      SUB_B:   state_nxt_s = COMP;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Moore output decode from the state register only.
  always_comb begin
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    sel_in = 1'b0;
    sel1   = 1'b0;
    sel2   = 1'b0;
    busy   = 1'b1;
    done   = 1'b0;
    case (state_r)
      IDLE: busy = 1'b0;
      LOAD_A: begin
        ld_a   = 1'b1;
        sel_in = 1'b1;
      end
      LOAD_B: begin
        ld_b   = 1'b1;
        sel_in = 1'b1;
      end
      COMP: busy = 1'b1;
      SUB_A: begin
        ld_a = 1'b1;
        sel2 = 1'b1;
      end
      SUB_B: begin
        ld_b = 1'b1;
        sel1 = 1'b1;
      end
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: drives gcd_ctrl through a small falling-edge-loaded datapath.
// Results are compared with a subtract-Euclid reference.
// Build with GCD_WDOG_EN defined to exercise the watchdog, with MAX_STEPS set to 4.
module tb_gcd_ctrl;

`ifdef GCD_WDOG_EN
  localparam logic [15:0] WD_MAX = 16'd4;
  localparam int          LIM    = 4;
`else
  localparam logic [15:0] WD_MAX = 16'd65535;
  localparam int          LIM    = 32'h4000_0000;
`endif

  logic clk, rst_n, start;
  logic lt, gt, eq, az, bz;
  logic ld_a, ld_b, sel_in, sel1, sel2, busy, done, res_sel, err;
  logic [15:0] opa, opb, ra, rb, data_in, sub_s;
  int checks = 0;
  int errors = 0;

  gcd_ctrl #(.MAX_STEPS(WD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .lt(lt), .gt(gt), .eq(eq), .az(az), .bz(bz),
    .ld_a(ld_a), .ld_b(ld_b), .sel_in(sel_in), .sel1(sel1), .sel2(sel2),
    .busy(busy), .done(done), .res_sel(res_sel), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench datapath: operand registers load on the falling edge.
  assign data_in = ld_a ? opa : opb;
  assign sub_s   = (sel1 ? rb : ra) - (sel2 ? rb : ra);
  assign lt = (ra < rb);
  assign gt = (ra > rb);
  assign eq = (ra == rb);
  assign az = (ra == 16'd0);
  assign bz = (rb == 16'd0);

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra <= 16'd0;
      rb <= 16'd0;
    end else begin
      if (ld_a) ra <= sel_in ? data_in : sub_s;
      if (ld_b) rb <= sel_in ? data_in : sub_s;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: Euclid by repeated subtraction with the same termination rules.
  function automatic void ref_gcd(input int a_in, input int b_in, input int lim,
                                  output int steps, output int res, output int rs, output int er);
    int a, b;
    a = a_in; b = b_in; steps = 0; res = 0; rs = 0; er = 0;
    for (int i = 0; i < 100000; i++) begin
      if (a == b) begin res = a; break; end
      if (a == 0) begin res = b; rs = 1; break; end
      if (b == 0) begin res = a; break; end
      if (steps >= lim) begin er = 1; res = a; break; end
      if (a > b) a = a - b; else b = b - a;
      steps++;
    end
  endfunction

  // mode: 0 = start low, 1 = random start noise, 2 = start held high.
  task automatic measure(input int k0, input int budget, input int mode,
                         output int kd, output int st);
    kd = -1; st = 0;
    for (int k = k0; k <= budget; k++) begin
      @(negedge clk);
      if ((ld_a || ld_b) && !sel_in) st++;
      if (done) begin kd = k; break; end
      if (mode == 0) start = 1'b0;
      else if (mode == 1) start = 1'($urandom_range(0, 1));
      else start = 1'b1;
    end
  endtask

  task automatic check_result(input string tag, input int kd, input int st,
                              input int es, input int eres, input int ers, input int eer);
    chk({tag, "_latency"}, kd, 4 + 2 * es);
    chk({tag, "_steps"}, st, es);
    chk({tag, "_res_sel"}, res_sel, ers);
    chk({tag, "_err"}, err, eer);
    if (eer == 0) chk({tag, "_result"}, res_sel ? rb : ra, eres);
  endtask

  task automatic run(input logic [15:0] a, input logic [15:0] b, input int mode,
                     input bit no_wait, input string tag);
    int es, eres, ers, eer, kd, st;
    ref_gcd(int'(a), int'(b), LIM, es, eres, ers, eer);
    opa = a; opb = b;
    if (!no_wait) @(negedge clk);
    start = 1'b1;
    measure(1, 4 + 2 * es + 8, mode, kd, st);
    start = 1'b0;
    check_result(tag, kd, st, es, eres, ers, eer);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_held"}, {res_sel, err}, {ers[0], eer[0]});
  endtask

  initial begin
    int es, eres, ers, eer, kd, st, found;
    rst_n = 1'b0; start = 1'b0; opa = 16'd0; opb = 16'd0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {ld_a, ld_b, sel_in, sel1, sel2, busy, done, res_sel, err}, 9'd0);

    // Leave reset and present start on the same edge.
    rst_n = 1'b1;
    run(16'd143, 16'd78, 0, 1'b1, "a143_b78");
    run(16'd25, 16'd25, 0, 1'b0, "a25_b25");
    run(16'd0, 16'd9, 0, 1'b0, "a0_b9");
    run(16'd5, 16'd0, 0, 1'b0, "a5_b0");
    run(16'd0, 16'd0, 0, 1'b0, "a0_b0");
    run(16'd143, 16'd78, 1, 1'b0, "start_noise");

`ifdef GCD_WDOG_EN
    run(16'd100, 16'd1, 0, 1'b0, "wdog_trip");
    run(16'd6, 16'd4, 0, 1'b0, "wdog_after");
`endif

    // Start held high: IDLE for one cycle after DONE, then a new run begins.
    ref_gcd(48, 18, LIM, es, eres, ers, eer);
    opa = 16'd48; opb = 16'd18;
    @(negedge clk);
    start = 1'b1;
    measure(1, 4 + 2 * es + 8, 2, kd, st);
    check_result("hold1", kd, st, es, eres, ers, eer);
    @(negedge clk);
    chk("hold_idle", busy, 1'b0);
    @(negedge clk);
    chk("hold_reload", {ld_a, sel_in}, 2'b11);
    start = 1'b0;
    measure(2, 4 + 2 * es + 8, 0, kd, st);
    check_result("hold2", kd, st, es, eres, ers, eer);

    // Asynchronous reset in the middle of a SUB_A cycle.
    opa = 16'd143; opb = 16'd78;
    @(negedge clk);
    start = 1'b1;
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (ld_a && !sel_in) begin found = 1; break; end
    end
    chk("reach_sub_a", found, 1);
    #2 rst_n = 1'b0;
    #1 chk("rst_async", {ld_a, ld_b, sel_in, sel1, sel2, busy, done, res_sel, err}, 9'd0);
    @(negedge clk);
    chk("rst_hold", {busy, done, res_sel, err}, 4'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_idle", busy, 1'b0);
    run(16'd21, 16'd14, 0, 1'b0, "after_reset");

    // Randomized operand pairs, including some zero operands.
    for (int i = 0; i < 14; i++) begin
      logic [15:0] ra_v, rb_v;
      ra_v = 16'($urandom_range(0, 200));
      rb_v = 16'($urandom_range(0, 200));
      if (i % 7 == 3) ra_v = 16'd0;
      if (i % 7 == 5) rb_v = 16'd0;
      run(ra_v, rb_v, i % 2, 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
